// File: rtl/jmb_mad_pipe_if.sv
// Handshake bundle for jmb_mad_pipe: input beat channel and result channel.
// The master side drives beats and out_ready; the slave side is the pipeline.
interface jmb_mad_pipe_if #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic             in_acc;
  logic [IN_W-1:0]  add_1;
  logic [IN_W-1:0]  add_2;
  logic [IN_W-1:0]  mult;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_acc, add_1, add_2, mult, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_acc, add_1, add_2, mult, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/jmb_mad_pipe.sv
// Two-stage pipelined (add_1 + add_2) * mult with optional running accumulation.
// Define JMB_MAD_SAT_EN to saturate on accumulator overflow instead of wrapping.
module jmb_mad_pipe #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 40
) (
  input  logic           clk,
  input  logic           rst_n,
  jmb_mad_pipe_if.slave  bus
);
  localparam int PROD_W = 2 * IN_W + 1;

  logic              v1_q, v1_d;
  logic [IN_W:0]     sum1_q, sum1_d;
  logic [IN_W-1:0]   mult1_q, mult1_d;
  logic              acc1_q, acc1_d;
  logic              v2_q, v2_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;

  logic              s1_load_s;
  logic              s2_load_s;
  logic              in_ready_s;
  logic [PROD_W-1:0] prod_w_s;
  logic [ACC_W-1:0]  prod_s;
  logic [ACC_W:0]    total_s;
  logic              ovf_s;
  logic [ACC_W-1:0]  result_s;

  // Pipeline advance: S2 frees up whenever its result is taken, so S1 can refill in the same cycle.
  always_comb begin
    s2_load_s  = v1_q && (!v2_q || bus.out_ready);
    in_ready_s = !v1_q || s2_load_s;
    s1_load_s  = bus.in_valid && in_ready_s;
  end

  // Stage 1 next state: carry-preserving sum plus the operands S2 needs.
  always_comb begin
    if (s1_load_s) begin
      sum1_d  = {1'b0, bus.add_1} + {1'b0, bus.add_2};
      mult1_d = bus.mult;
      acc1_d  = bus.in_acc;
    end else begin
      sum1_d  = sum1_q;
      mult1_d = mult1_q;
      acc1_d  = acc1_q;
    end
    if (s1_load_s) begin
      v1_d = 1'b1;
    end else if (s2_load_s) begin
      v1_d = 1'b0;
    end else begin
      v1_d = v1_q;
    end
  end

  // Stage 2 datapath: the presented result doubles as the accumulator.
  always_comb begin
    prod_w_s = PROD_W'(sum1_q) * PROD_W'(mult1_q);
    prod_s   = ACC_W'(prod_w_s);
    if (acc1_q) begin
      total_s = {1'b0, out_data_q} + {1'b0, prod_s};
    end else begin
      total_s = {1'b0, prod_s};
    end
    ovf_s = total_s[ACC_W];
`ifdef JMB_MAD_SAT_EN
    if (ovf_s) begin
      result_s = {ACC_W{1'b1}};
    end else begin
      result_s = total_s[ACC_W-1:0];
    end
`else
    result_s = total_s[ACC_W-1:0];
`endif
  end

  // Stage 2 next state: result held stable while the consumer stalls.
  always_comb begin
    if (s2_load_s) begin
      v2_d       = 1'b1;
      out_data_d = result_s;
      out_ovf_d  = ovf_s;
    end else if (bus.out_ready) begin
      v2_d       = 1'b0;
      out_data_d = out_data_q;
      out_ovf_d  = out_ovf_q;
    end else begin
      v2_d       = v2_q;
      out_data_d = out_data_q;
      out_ovf_d  = out_ovf_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      sum1_q     <= '0;
      mult1_q    <= '0;
      acc1_q     <= 1'b0;
      v2_q       <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      sum1_q     <= sum1_d;
      mult1_q    <= mult1_d;
      acc1_q     <= acc1_d;
      v2_q       <= v2_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = v2_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_jmb_mad_pipe.sv
// Scoreboard bench for jmb_mad_pipe: a 40-bit instance for the main flows and a
// 33-bit instance for the accumulator overflow boundary.
module tb_jmb_mad_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jmb_mad_pipe_if #(.IN_W(16), .ACC_W(40)) b40 ();
  jmb_mad_pipe_if #(.IN_W(16), .ACC_W(33)) b33 ();

  jmb_mad_pipe #(.IN_W(16), .ACC_W(40)) dut40 (.clk(clk), .rst_n(rst_n), .bus(b40));
  jmb_mad_pipe #(.IN_W(16), .ACC_W(33)) dut33 (.clk(clk), .rst_n(rst_n), .bus(b33));

  int errors = 0;
  int checks = 0;
  longint unsigned exp_data[$];
  bit              exp_ovf[$];
  longint unsigned model_acc [2];

  bit              in_fire, out_fire, obs_valid, obs_irdy, obs_ovf;
  longint unsigned obs_data;

  // Reference arithmetic in 64 bits, reduced to the instance width afterwards.
  function automatic void push_model(input int sel, input bit acc,
                                     input logic [15:0] a1, input logic [15:0] a2,
                                     input logic [15:0] m);
    int w;
    longint unsigned prod, full, mask, res;
    bit ovf;
    w    = (sel == 1) ? 33 : 40;
    prod = (64'(a1) + 64'(a2)) * 64'(m);
    full = (acc ? model_acc[sel] : 64'd0) + prod;
    mask = (64'd1 << w) - 64'd1;
    ovf  = (full >> w) != 64'd0;
`ifdef JMB_MAD_SAT_EN
    res = ovf ? mask : (full & mask);
`else
    res = full & mask;
`endif
    model_acc[sel] = res;
    exp_data.push_back(res);
    exp_ovf.push_back(ovf);
  endfunction

  // One clock of stimulus on the selected instance; the other one idles and drains.
  task automatic step(input int sel, input bit vld, input bit acc,
                      input logic [15:0] a1, input logic [15:0] a2,
                      input logic [15:0] m, input bit ordy);
    @(negedge clk);
    if (sel == 1) begin
      b33.in_valid = vld; b33.in_acc = acc; b33.add_1 = a1; b33.add_2 = a2;
      b33.mult = m; b33.out_ready = ordy;
      b40.in_valid = 1'b0; b40.out_ready = 1'b1;
    end else begin
      b40.in_valid = vld; b40.in_acc = acc; b40.add_1 = a1; b40.add_2 = a2;
      b40.mult = m; b40.out_ready = ordy;
      b33.in_valid = 1'b0; b33.out_ready = 1'b1;
    end
    #1;
    if (sel == 1) begin
      obs_irdy = b33.in_ready; obs_valid = b33.out_valid;
      obs_data = 64'(b33.out_data); obs_ovf = b33.out_ovf;
    end else begin
      obs_irdy = b40.in_ready; obs_valid = b40.out_valid;
      obs_data = 64'(b40.out_data); obs_ovf = b40.out_ovf;
    end
    in_fire  = vld && obs_irdy;
    out_fire = obs_valid && ordy;
    if (in_fire) push_model(sel, acc, a1, a2, m);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b40.in_valid = 1'b0; b40.in_acc = 1'b0; b40.add_1 = 16'd0; b40.add_2 = 16'd0;
    b40.mult = 16'd0; b40.out_ready = 1'b1;
    b33.in_valid = 1'b0; b33.in_acc = 1'b0; b33.add_1 = 16'd0; b33.add_2 = 16'd0;
    b33.mult = 16'd0; b33.out_ready = 1'b1;
    model_acc[0] = 64'd0; model_acc[1] = 64'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", obs_valid); end
    checks++; if (obs_data !== 64'd0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", obs_data); end
    checks++; if (obs_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got=%0b exp=0", obs_ovf); end
    checks++; if (obs_irdy !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", obs_irdy); end
    checks++; if (b33.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid33 got=%0b exp=0", b33.out_valid); end
  endtask

  task automatic test_carry();
    longint unsigned ed; bit eo;
    step(0, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0002, 1'b1);
    checks++; if (in_fire !== 1'b1) begin errors++; $display("FAIL carry_accept got=%0b exp=1", in_fire); end
    step(0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL carry_latency_early got=%0b exp=0", obs_valid); end
    step(0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
    checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL carry_latency got=%0b exp=1", obs_valid); end
    checks++;
    if ({obs_ovf, obs_data} !== {1'b0, 64'h0_0002_0000}) begin
      errors++; $display("FAIL carry_value got=%h ovf=%0b exp=20000 ovf=0", obs_data, obs_ovf);
    end
    if (out_fire && exp_data.size() > 0) begin
      ed = exp_data.pop_front(); eo = exp_ovf.pop_front();
      checks++; if ({obs_ovf, obs_data} !== {eo, ed}) begin errors++; $display("FAIL carry_model got=%h/%0b exp=%h/%0b", obs_data, obs_ovf, ed, eo); end
    end
  endtask

  task automatic test_stream();
    int fire_cyc[$];
    longint unsigned ed; bit eo;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) step(0, 1'b1, (c != 0), 16'd1, 16'd1, 16'd3, 1'b1);
      else       step(0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
      if (c < 4) begin
        checks++; if (in_fire !== 1'b1) begin errors++; $display("FAIL stream_accept beat=%0d got=%0b exp=1", c, in_fire); end
      end
      if (out_fire) begin
        checks++;
        if (obs_data !== 64'(6 * (fire_cyc.size() + 1))) begin
          errors++; $display("FAIL stream_value got=%0d exp=%0d", obs_data, 6 * (fire_cyc.size() + 1));
        end
        fire_cyc.push_back(c);
        checks++;
        if (exp_data.size() == 0) begin errors++; $display("FAIL stream_extra got=%h exp=none", obs_data); end
        else begin
          ed = exp_data.pop_front(); eo = exp_ovf.pop_front();
          if ({obs_ovf, obs_data} !== {eo, ed}) begin errors++; $display("FAIL stream_model got=%h/%0b exp=%h/%0b", obs_data, obs_ovf, ed, eo); end
        end
      end
    end
    checks++;
    if (fire_cyc.size() != 4 || fire_cyc[0] != 2 || fire_cyc[3] != 5) begin
      errors++; $display("FAIL stream_timing got=%0d outputs exp=4 on cycles 2..5", fire_cyc.size());
    end
  endtask

  task automatic test_stall();
    logic [15:0] sa1 [3] = '{16'd2, 16'd1, 16'd5};
    logic [15:0] sa2 [3] = '{16'd3, 16'd0, 16'd5};
    logic [15:0] sm  [3] = '{16'd4, 16'd7, 16'd1};
    bit          sac [3] = '{1'b0, 1'b1, 1'b1};
    int nb = 0, got = 0;
    longint unsigned held = 64'd0, ed; bit have_held = 1'b0, eo;
    for (int c = 0; c < 5; c++) begin
      step(0, 1'b1, sac[nb], sa1[nb], sa2[nb], sm[nb], 1'b0);
      if (in_fire) nb++;
      if (c >= 2) begin
        checks++; if (obs_irdy !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", c, obs_irdy); end
      end
      if (obs_valid) begin
        if (have_held) begin
          checks++; if (obs_data !== held) begin errors++; $display("FAIL stall_hold got=%h exp=%h", obs_data, held); end
        end else begin
          held = obs_data; have_held = 1'b1;
        end
      end
    end
    checks++; if (nb != 2) begin errors++; $display("FAIL stall_accepted got=%0d exp=2", nb); end
    for (int c = 0; c < 10; c++) begin
      if (nb < 3) step(0, 1'b1, sac[nb], sa1[nb], sa2[nb], sm[nb], 1'b1);
      else        step(0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
      if (in_fire) nb++;
      if (out_fire) begin
        got++;
        checks++;
        if (exp_data.size() == 0) begin errors++; $display("FAIL stall_extra got=%h exp=none", obs_data); end
        else begin
          ed = exp_data.pop_front(); eo = exp_ovf.pop_front();
          if ({obs_ovf, obs_data} !== {eo, ed}) begin errors++; $display("FAIL stall_order got=%h/%0b exp=%h/%0b", obs_data, obs_ovf, ed, eo); end
        end
      end
    end
    checks++; if (got != 3 || exp_data.size() != 0) begin errors++; $display("FAIL stall_count got=%0d exp=3", got); end
  endtask

  task automatic test_overflow();
    logic [15:0] oa1 [5] = '{16'hFFFF, 16'h5D17, 16'd1, 16'd1, 16'd3};
    logic [15:0] oa2 [5] = '{16'hFFFF, 16'd0,    16'd1, 16'd0, 16'd0};
    logic [15:0] om  [5] = '{16'hFFFF, 16'h000B, 16'd1, 16'd1, 16'd3};
    bit          oac [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int nb = 0, got = 0;
    longint unsigned ed, spec_data; bit eo;
`ifdef JMB_MAD_SAT_EN
    spec_data = 64'h1_FFFF_FFFF;
`else
    spec_data = 64'd1;
`endif
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (nb < 5) step(1, 1'b1, oac[nb], oa1[nb], oa2[nb], om[nb], 1'b1);
      else        step(1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
      if (in_fire) nb++;
      if (out_fire) begin
        if (got == 1) begin
          checks++; if (obs_data !== 64'h1_FFFF_FFFF) begin errors++; $display("FAIL ovf_preload got=%h exp=1ffffffff", obs_data); end
        end
        if (got == 2) begin
          checks++;
          if ({obs_ovf, obs_data} !== {1'b1, spec_data}) begin
            errors++; $display("FAIL ovf_boundary got=%h/%0b exp=%h/1", obs_data, obs_ovf, spec_data);
          end
        end
        got++;
        checks++;
        if (exp_data.size() == 0) begin errors++; $display("FAIL ovf_extra got=%h exp=none", obs_data); end
        else begin
          ed = exp_data.pop_front(); eo = exp_ovf.pop_front();
          if ({obs_ovf, obs_data} !== {eo, ed}) begin errors++; $display("FAIL ovf_model got=%h/%0b exp=%h/%0b", obs_data, obs_ovf, ed, eo); end
        end
      end
    end
    checks++; if (got != 5) begin errors++; $display("FAIL ovf_count got=%0d exp=5", got); end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    longint unsigned ed; bit eo;
    step(0, 1'b1, 1'b0, 16'd3, 16'd4, 16'd5, 1'b0);
    step(0, 1'b1, 1'b1, 16'd1, 16'd1, 16'd1, 1'b0);
    step(0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    checks++; if ({obs_valid, obs_irdy} !== 2'b10) begin errors++; $display("FAIL rmid_full got=v%0b r%0b exp=v1 r0", obs_valid, obs_irdy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (b40.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got=%0b exp=0", b40.out_valid); end
    checks++; if (b40.out_data !== 40'd0) begin errors++; $display("FAIL rmid_out_data got=%h exp=0", b40.out_data); end
    exp_data.delete(); exp_ovf.delete();
    model_acc[0] = 64'd0; model_acc[1] = 64'd0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(0, 1'b1, 1'b1, 16'd2, 16'd0, 16'd5, 1'b1);
    checks++; if (in_fire !== 1'b1) begin errors++; $display("FAIL rmid_accept got=%0b exp=1", in_fire); end
    for (int c = 0; c < 6; c++) begin
      step(0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
      if (out_fire) begin
        got++;
        checks++; if (obs_data !== 64'd10) begin errors++; $display("FAIL rmid_value got=%0d exp=10", obs_data); end
        if (exp_data.size() > 0) begin
          ed = exp_data.pop_front(); eo = exp_ovf.pop_front();
          checks++; if ({obs_ovf, obs_data} !== {eo, ed}) begin errors++; $display("FAIL rmid_model got=%h/%0b exp=%h/%0b", obs_data, obs_ovf, ed, eo); end
        end
      end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL rmid_count got=%0d exp=1", got); end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 5; c++) begin
      step(0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
      checks++;
      if ({obs_valid, obs_data} !== {1'b0, model_acc[0]}) begin
        errors++; $display("FAIL idle_hold got=v%0b %h exp=v0 %h", obs_valid, obs_data, model_acc[0]);
      end
    end
  endtask

  task automatic test_random();
    int sent = 0, got = 0;
    bit have_cur = 1'b0, cur_acc = 1'b0, vld, ordy, prev_stall = 1'b0, prev_ovf = 1'b0, eo;
    logic [15:0] ca1 = 16'd0, ca2 = 16'd0, cm = 16'd0;
    longint unsigned prev_data = 64'd0, ed;
    for (int c = 0; c < 60000 && got < 10000; c++) begin
      if (!have_cur && sent < 10000) begin
        ca1 = 16'($urandom_range(0, 65535)); ca2 = 16'($urandom_range(0, 65535));
        cm  = 16'($urandom_range(0, 65535)); cur_acc = ($urandom_range(0, 7) != 0);
        have_cur = 1'b1;
      end
      vld  = have_cur && ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      step(0, vld, cur_acc, ca1, ca2, cm, ordy);
      if (prev_stall) begin
        checks++;
        if ({obs_valid, obs_ovf, obs_data} !== {1'b1, prev_ovf, prev_data}) begin
          errors++; $display("FAIL rand_stall_hold got=%h exp=%h", obs_data, prev_data);
        end
      end
      prev_stall = obs_valid && !ordy; prev_data = obs_data; prev_ovf = obs_ovf;
      if (in_fire) begin sent++; have_cur = 1'b0; end
      if (out_fire) begin
        got++;
        checks++;
        if (exp_data.size() == 0) begin errors++; $display("FAIL rand_extra got=%h exp=none", obs_data); end
        else begin
          ed = exp_data.pop_front(); eo = exp_ovf.pop_front();
          if ({obs_ovf, obs_data} !== {eo, ed}) begin errors++; $display("FAIL rand_model beat=%0d got=%h/%0b exp=%h/%0b", got, obs_data, obs_ovf, ed, eo); end
        end
      end
    end
    checks++;
    if (got != 10000 || exp_data.size() != 0) begin
      errors++; $display("FAIL rand_count got=%0d pending=%0d exp=10000 pending=0", got, exp_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_stream();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
